// File: rtl/pad_frame_ctrl_if.sv
// rtl/pad_frame_ctrl_if.sv - source, padder and status signals of pad_frame_ctrl
// perf_cycles is present only when PAD_CTRL_PERF_EN is defined.
interface pad_frame_ctrl_if #(
  parameter int D       = 220,
  parameter int DRAIN_X = 4
);
  localparam int CNT_W = $clog2((D + 2) * (D + 2) + DRAIN_X + 1);

  logic             start;
  logic             src_valid;
  logic             src_ready;
  logic             pad_en;
  logic             pad_valid;
  logic             out_valid;
  logic [CNT_W-1:0] out_row;
  logic [CNT_W-1:0] out_col;
  logic             busy;
  logic             frame_done;
  logic             err_start;
  logic             err_timeout;
`ifdef PAD_CTRL_PERF_EN
  logic [31:0]      perf_cycles;

  modport master (
    output start, src_valid, pad_valid,
    input  src_ready, pad_en, out_valid, out_row, out_col,
    input  busy, frame_done, err_start, err_timeout, perf_cycles
  );

  modport slave (
    input  start, src_valid, pad_valid,
    output src_ready, pad_en, out_valid, out_row, out_col,
    output busy, frame_done, err_start, err_timeout, perf_cycles
  );
`else
  modport master (
    output start, src_valid, pad_valid,
    input  src_ready, pad_en, out_valid, out_row, out_col,
    input  busy, frame_done, err_start, err_timeout
  );

  modport slave (
    input  start, src_valid, pad_valid,
    output src_ready, pad_en, out_valid, out_row, out_col,
    output busy, frame_done, err_start, err_timeout
  );
`endif
endinterface

// File: rtl/pad_frame_ctrl.sv
// rtl/pad_frame_ctrl.sv - frame sequencer: loads a DxD frame, drains (D+2)*D padded beats
// Optional cycle counter perf_cycles when PAD_CTRL_PERF_EN is defined.
module pad_frame_ctrl #(
  parameter int D       = 220,
  parameter int DRAIN_X = 4
) (
  input  logic             clk,
  input  logic             reset,
  pad_frame_ctrl_if.slave  bus
);
  localparam int CNT_W     = $clog2((D + 2) * (D + 2) + DRAIN_X + 1);
  localparam int IN_LAST   = D * D - 1;
  localparam int OUT_TOTAL = (D + 2) * D;
  localparam int DRAIN_MAX = OUT_TOTAL + DRAIN_X;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_in_cnt;
  logic [CNT_W-1:0] r_out_cnt;
  logic [CNT_W-1:0] r_drain_cnt;
  logic [CNT_W-1:0] r_row;
  logic [CNT_W-1:0] r_col;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_out_row;
  logic [CNT_W-1:0] r_out_col;
  logic             r_err_start;
  logic             r_err_timeout;

  logic             w_src_ready;
  logic             w_pad_en;
  logic             w_accept;
  logic             w_start_ok;
  logic             w_drain_beat;
  logic             w_count_exit;
  logic             w_timeout_exit;

  assign w_start_ok   = (r_state == S_IDLE) && bus.start;
  assign w_drain_beat = (r_state == S_DRAIN) && bus.pad_valid;

  always_comb begin
    w_state_nxt    = r_state;
    w_src_ready    = 1'b0;
    w_pad_en       = 1'b0;
    w_accept       = 1'b0;
    w_count_exit   = 1'b0;
    w_timeout_exit = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        w_src_ready = 1'b1;
        w_pad_en    = bus.src_valid;
        w_accept    = bus.src_valid;
        if (bus.src_valid && (r_in_cnt == CNT_W'(IN_LAST))) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        w_pad_en = 1'b1;
        // Beat-count exit takes priority over a coincident timeout.
        w_count_exit   = bus.pad_valid && (r_out_cnt + CNT_W'(1) == CNT_W'(OUT_TOTAL));
        w_timeout_exit = !w_count_exit && (r_drain_cnt + CNT_W'(1) == CNT_W'(DRAIN_MAX));
        if (w_count_exit || w_timeout_exit) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_in_cnt      <= '0;
      r_out_cnt     <= '0;
      r_drain_cnt   <= '0;
      r_row         <= '0;
      r_col         <= '0;
      r_out_valid   <= 1'b0;
      r_out_row     <= '0;
      r_out_col     <= '0;
      r_err_start   <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_in_cnt    <= '0;
        r_out_cnt   <= '0;
        r_drain_cnt <= '0;
        r_row       <= '0;
        r_col       <= '0;
      end
      if (w_accept) r_in_cnt <= r_in_cnt + CNT_W'(1);
      if (r_state == S_DRAIN) r_drain_cnt <= r_drain_cnt + CNT_W'(1);
      if (w_drain_beat) begin
        r_out_cnt <= r_out_cnt + CNT_W'(1);
        if (r_col == CNT_W'(D + 1)) begin
          r_col <= '0;
          r_row <= r_row + CNT_W'(1);
        end else begin
          r_col <= r_col + CNT_W'(1);
        end
      end
      // Coordinates only move with a beat so they hold while out_valid is low.
      r_out_valid <= w_drain_beat;
      if (w_drain_beat) begin
        r_out_row <= r_row;
        r_out_col <= r_col;
      end
      if (bus.start && (r_state != S_IDLE)) r_err_start <= 1'b1;
      if (w_timeout_exit) r_err_timeout <= 1'b1;
    end
  end

`ifdef PAD_CTRL_PERF_EN
  logic [31:0] r_perf_cycles;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_cycles <= '0;
    end else if (w_start_ok) begin
      r_perf_cycles <= '0;
    end else if ((r_state != S_IDLE) && (r_perf_cycles != 32'hFFFF_FFFF)) begin
      r_perf_cycles <= r_perf_cycles + 32'd1;
    end
  end

  assign bus.perf_cycles = r_perf_cycles;
`endif

  // Handshake outputs drop in the reset cycle itself, not one edge later.
  assign bus.src_ready   = w_src_ready && !reset;
  assign bus.pad_en      = w_pad_en && !reset;
  assign bus.busy        = (r_state != S_IDLE) && !reset;
  assign bus.frame_done  = (r_state == S_DONE) && !reset;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_row     = r_out_row;
  assign bus.out_col     = r_out_col;
  assign bus.err_start   = r_err_start;
  assign bus.err_timeout = r_err_timeout;

endmodule
